// File: rtl/pc_sequencer_pkg.sv
// definitions: shared types and default widths for the PC sequencer.
//   pc_state_e - run/halt state of the processor
//   branch_t   - branch request bundle from decoder/ALU
package definitions;

    localparam int unsigned PC_W_DEF  = 10;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned BOFF_W    = 8;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} pc_state_e;

    typedef struct packed {
        logic              valid;
        logic [BOFF_W-1:0] offset;
        logic              sign;
    } branch_t;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable, stops at all-ones
//   count      : registered count value
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-instruction-address generation and run/halt control.
//   CLK, RST_N     : clock, async active-low reset
//   START          : pulse that (re)starts execution from START_ADDR
//   BRANCH, bOFFSET, bSIGN : branch request and signed-magnitude offset
//   SRESET, HALT   : ALU soft reset / halt
//   PC             : current instruction address
//   RUNNING, DONE  : state flags (RUN / HALTED)
//   CYCLES         : saturating count of RUN cycles since last START
module pc_sequencer
    import definitions::*;
#(
    parameter int unsigned PC_W       = PC_W_DEF,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              BRANCH,
    input  logic [BOFF_W-1:0] bOFFSET,
    input  logic              bSIGN,
    input  logic              SRESET,
    input  logic              HALT,
    output logic [PC_W-1:0]   PC,
    output logic              RUNNING,
    output logic              DONE,
    output logic [CNT_W-1:0]  CYCLES
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            cnt_clr, cnt_en;
    branch_t         br;
    logic [PC_W-1:0] off_ext;

    assign br      = '{valid: BRANCH, offset: bOFFSET, sign: bSIGN};
    assign off_ext = PC_W'(br.offset);

    // Next-state, next-PC and counter control
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                if (START) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                if (SRESET && HALT) begin
                    state_d = HALTED;
                end else if (SRESET) begin
                    pc_d = START_PC;
                end else if (br.valid) begin
                    // wraps modulo 2^PC_W; not-taken branch arrives as +1
                    pc_d = br.sign ? (pc_q - off_ext) : (pc_q + off_ext);
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == HALTED);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (CYCLES)
    );

    assign PC      = pc_q;
    assign RUNNING = running_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized + directed bench for pc_sequencer against an
// arithmetic reference model (modular PC arithmetic, saturating count).
module tb_pc_sequencer;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 16;
    localparam int MODV = 1024;
    localparam int CMAX = 65535;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             START = 1'b0;
    logic             BRANCH = 1'b0;
    logic [7:0]       bOFFSET = 8'd0;
    logic             bSIGN = 1'b0;
    logic             SRESET = 1'b0;
    logic             HALT = 1'b0;
    logic [PC_W-1:0]  PC;
    logic             RUNNING;
    logic             DONE;
    logic [CNT_W-1:0] CYCLES;

    pc_sequencer dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .START   (START),
        .BRANCH  (BRANCH),
        .bOFFSET (bOFFSET),
        .bSIGN   (bSIGN),
        .SRESET  (SRESET),
        .HALT    (HALT),
        .PC      (PC),
        .RUNNING (RUNNING),
        .DONE    (DONE),
        .CYCLES  (CYCLES)
    );

    always #5 CLK = ~CLK;

    function automatic int wrap(int v);
        return ((v % MODV) + MODV) % MODV;
    endfunction

    // Reference model: 0 = idle, 1 = running, 2 = halted
    int m_st = 0;
    int m_pc = 0;
    int m_cyc = 0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_st  <= 0;
            m_pc  <= 0;
            m_cyc <= 0;
        end else if (m_st == 1) begin
            m_cyc <= (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
            if (SRESET && HALT) m_st <= 2;
            else if (SRESET) m_pc <= 0;
            else if (BRANCH) m_pc <= wrap(bSIGN ? m_pc - int'(bOFFSET) : m_pc + int'(bOFFSET));
            else m_pc <= wrap(m_pc + 1);
        end else if (START) begin
            m_st  <= 1;
            m_pc  <= 0;
            m_cyc <= 0;
        end
    end

    // Hand-computed expectations posted by the stimulus (-1 = don't care)
    logic  lit_en = 1'b0;
    string lit_name = "";
    int    l_pc = -1, l_run = -1, l_done = -1, l_cyc = -1;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void cmp(string nm, int act, int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Single compare process: model every cycle, literals when posted
    always @(negedge CLK) begin
        if (RST_N) begin
            cmp("model.pc", int'(PC), m_pc);
            cmp("model.running", int'(RUNNING), (m_st == 1) ? 1 : 0);
            cmp("model.done", int'(DONE), (m_st == 2) ? 1 : 0);
            cmp("model.cycles", int'(CYCLES), m_cyc);
        end
        if (lit_en) begin
            if (l_pc >= 0)   cmp({lit_name, ".pc"}, int'(PC), l_pc);
            if (l_run >= 0)  cmp({lit_name, ".running"}, int'(RUNNING), l_run);
            if (l_done >= 0) cmp({lit_name, ".done"}, int'(DONE), l_done);
            if (l_cyc >= 0)  cmp({lit_name, ".cycles"}, int'(CYCLES), l_cyc);
        end
    end

    task automatic step(bit st, bit br, int off, bit sg, bit sr, bit hl);
        START   = st;
        BRANCH  = br;
        bOFFSET = 8'(off);
        bSIGN   = sg;
        SRESET  = sr;
        HALT    = hl;
        @(posedge CLK);
        lit_en = 1'b0;
        #2;
    endtask

    task automatic ex(string nm, int p, int r, int d, int c);
        lit_name = nm;
        l_pc     = p;
        l_run    = r;
        l_done   = d;
        l_cyc    = c;
        lit_en   = 1'b1;
    endtask

    task automatic plain();
        step(0, 0, 0, 0, 0, 0);
    endtask

    // Reach a target PC in RUN using branches of at most 255
    task automatic goto_br(int tgt);
        int d;
        for (int g = 0; g < 20 && m_pc != tgt; g++) begin
            d = wrap(tgt - m_pc);
            if (d <= 255) step(0, 1, d, 0, 0, 0);
            else if (MODV - d <= 255) step(0, 1, MODV - d, 1, 0, 0);
            else step(0, 1, 255, 0, 0, 0);
        end
    endtask

    initial begin
        int c_h;
        bit r_st, r_sr, r_hl;

        // reset
        plain();
        ex("reset", 0, 0, 0, 0);
        plain();
        RST_N = 1'b1;
        plain();
        ex("idle", 0, 0, 0, 0);

        // start and sequential fetch
        step(1, 0, 0, 0, 0, 0);
        ex("start", 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            plain();
            ex("seq", i, 1, 0, i);
        end
        for (int i = 0; i < 30 && m_pc != 20; i++) plain();

        // branches
        step(0, 1, 6, 0, 0, 0);
        ex("br_fwd", 26, 1, 0, -1);
        step(0, 1, 10, 1, 0, 0);
        ex("br_back", 16, 1, 0, -1);
        step(0, 1, 1, 0, 0, 0);
        ex("br_nt", 17, 1, 0, -1);

        // wrap-around
        goto_br(1020);
        step(0, 1, 8, 0, 0, 0);
        ex("wrap_fwd", 4, 1, 0, -1);
        step(0, 1, 1, 1, 0, 0);
        ex("back1", 3, 1, 0, -1);
        step(0, 1, 5, 1, 0, 0);
        ex("wrap_back", 1022, 1, 0, -1);
        step(0, 1, 0, 1, 0, 0);
        ex("self_loop", 1022, 1, 0, -1);

        // soft reset and halt
        goto_br(40);
        step(0, 0, 0, 0, 1, 0);
        ex("sreset", 0, 1, 0, -1);
        goto_br(55);
        step(0, 0, 0, 0, 1, 1);
        ex("halt", 55, 0, 1, -1);
        c_h = m_cyc;
        for (int i = 0; i < 5; i++) step(0, 1, $urandom_range(0, 255), 1'($urandom), 1'($urandom), 1'($urandom));
        ex("halted_hold", 55, 0, 1, c_h);

        // restart from HALTED, halt beats branch
        step(1, 0, 0, 0, 0, 0);
        ex("restart", 0, 1, 0, 0);
        goto_br(30);
        step(0, 1, 3, 0, 1, 1);
        ex("all_high", 30, 0, 1, -1);
        step(1, 0, 0, 0, 0, 0);
        ex("restart2", 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) plain();
        step(1, 0, 0, 0, 0, 0);
        ex("start_in_run", 4, 1, 0, 4);

        // asynchronous reset mid-cycle
        goto_br(77);
        RST_N = 1'b0;
        #1;
        ex("async_rst", 0, 0, 0, 0);
        plain();
        RST_N = 1'b1;

        // randomized run
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r_st = ($urandom_range(0, 29) == 0);
            r_sr = ($urandom_range(0, 15) == 0);
            r_hl = ($urandom_range(0, 3) == 0);
            step(r_st, 1'($urandom), $urandom_range(0, 255), 1'($urandom), r_sr, r_hl);
        end

        // saturation of the cycle counter
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < CMAX; i++) begin
            step(1'($urandom), 1'($urandom), $urandom_range(0, 255), 1'($urandom),
                 ($urandom_range(0, 63) == 0), 1'b0);
        end
        ex("sat", -1, 1, 0, 65535);
        plain();
        ex("sat_hold", -1, 1, 0, 65535);
        plain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
